// File: rtl/recurrence_pkg.sv
// Shared types and constants for the four-register recurrence sequencer.
package recurrence_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Step codes follow the update order a, d, b, c.
  typedef enum logic [1:0] {
    STEP_A = 2'd0,
    STEP_D = 2'd1,
    STEP_B = 2'd2,
    STEP_C = 2'd3
  } step_t;

  localparam int SUB_D = 3;
  localparam int ADD_B = 10;

endpackage

// File: rtl/recurrence_sequencer_if.sv
// Control/data bundle between a parent (master) and the recurrence sequencer (slave).
interface recurrence_sequencer_if #(
  parameter int W  = 32,
  parameter int IW = 8
);

  logic          start;
  logic          abort;
  logic [IW-1:0] iters;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic [W-1:0]  c_in;
  logic [W-1:0]  d_in;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  c;
  logic [W-1:0]  d;
  logic          busy;
  logic          done;
  logic [1:0]    step;
  logic [IW-1:0] iter;

  modport master (
    output start, abort, iters, a_in, b_in, c_in, d_in,
    input  a, b, c, d, busy, done, step, iter
  );

  modport slave (
    input  start, abort, iters, a_in, b_in, c_in, d_in,
    output a, b, c, d, busy, done, step, iter
  );

endinterface

// File: rtl/step_delay_counter.sv
// Free-running step timer: counts 0..STEP_CYCLES-1 while enabled, tick marks the last count.
module step_delay_counter #(
  parameter int STEP_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  assign tick = en && (r_count == LAST);

endmodule

// File: rtl/recurrence_sequencer.sv
// Start/busy/done sequencer running a = b + c; d = a - 3; b = d + 10; c = c + 1
// for a programmable number of iterations, one update per timer tick.
module recurrence_sequencer
  import recurrence_pkg::*;
#(
  parameter int W           = 32,
  parameter int IW          = 8,
  parameter int STEP_CYCLES = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  recurrence_sequencer_if.slave bus
);

  state_t        r_state, w_stateNext;
  step_t         r_step, w_stepNext;
  logic [W-1:0]  r_a, r_b, r_c, r_d;
  logic [W-1:0]  w_aNext, w_bNext, w_cNext, w_dNext;
  logic [IW-1:0] r_limit, w_limitNext;
  logic [IW-1:0] r_iter, w_iterNext;
  logic          r_done, w_doneNext;
  logic          w_timerEn, w_timerClr, w_tick;

  step_delay_counter #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .en  (w_timerEn),
    .clr (w_timerClr),
    .tick(w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_step  <= STEP_A;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_limit <= '0;
      r_iter  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_step  <= w_stepNext;
      r_a     <= w_aNext;
      r_b     <= w_bNext;
      r_c     <= w_cNext;
      r_d     <= w_dNext;
      r_limit <= w_limitNext;
      r_iter  <= w_iterNext;
      r_done  <= w_doneNext;
    end
  end

  // Abort takes priority over both a new start and a pending update.
  always_comb begin
    w_stateNext = r_state;
    w_stepNext  = r_step;
    w_aNext     = r_a;
    w_bNext     = r_b;
    w_cNext     = r_c;
    w_dNext     = r_d;
    w_limitNext = r_limit;
    w_iterNext  = r_iter;
    w_doneNext  = 1'b0;
    w_timerEn   = 1'b0;
    w_timerClr  = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          w_aNext     = bus.a_in;
          w_bNext     = bus.b_in;
          w_cNext     = bus.c_in;
          w_dNext     = bus.d_in;
          w_limitNext = bus.iters;
          w_stepNext  = STEP_A;
          w_iterNext  = '0;
          w_timerClr  = 1'b1;
          if (bus.iters != '0) begin
            w_stateNext = RUN;
          end else begin
            w_doneNext = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          w_stateNext = IDLE;
          w_timerClr  = 1'b1;
        end else begin
          w_timerEn = 1'b1;
          if (w_tick) begin
            case (r_step)
              STEP_A: w_aNext = r_b + r_c;
              STEP_D: w_dNext = r_a - W'(SUB_D);
              STEP_B: w_bNext = r_d + W'(ADD_B);
              STEP_C: w_cNext = r_c + 1'b1;
              default: ;
            endcase
            w_stepNext = step_t'(r_step + 2'd1);
            if (r_step == STEP_C) begin
              w_iterNext = r_iter + 1'b1;
              if (r_iter == r_limit - IW'(1)) begin
                w_stateNext = IDLE;
                w_doneNext  = 1'b1;
              end
            end
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign bus.a    = r_a;
  assign bus.b    = r_b;
  assign bus.c    = r_c;
  assign bus.d    = r_d;
  assign bus.busy = (r_state == RUN);
  assign bus.done = r_done;
  assign bus.step = r_step;
  assign bus.iter = r_iter;

endmodule

// File: tb/tb_recurrence_sequencer.sv
// Scoreboard bench for recurrence_sequencer: each accepted start pushes the modelled
// final/mid-run values and timing, which are popped and compared when done pulses.
module tb_recurrence_sequencer;

  localparam int W    = 32;
  localparam int IW   = 8;
  localparam int STEP = 5;

  typedef struct {
    logic [W-1:0] a, b, c, d;
    logic [W-1:0] midA, midB, midC, midD;
    int           iters;
    int           latency;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sbQ[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  recurrence_sequencer_if #(.W(W), .IW(IW)) bus ();

  recurrence_sequencer #(
    .W(W), .IW(IW), .STEP_CYCLES(STEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Straight-line reference for the recurrence, iterated it times.
  function automatic void model(input logic [W-1:0] ai, bi, ci, di, input int it,
                                output logic [W-1:0] ao, bo, co, dOut);
    logic [W-1:0] ta, tb, tc, td;
    ta = ai; tb = bi; tc = ci; td = di;
    for (int i = 0; i < it; i++) begin
      ta = tb + tc;
      td = ta - 32'd3;
      tb = td + 32'd10;
      tc = tc + 32'd1;
    end
    ao = ta; bo = tb; co = tc; dOut = td;
  endfunction

  task automatic pushExpected(input logic [W-1:0] ai, bi, ci, di, input int it);
    exp_t e;
    model(ai, bi, ci, di, it, e.a, e.b, e.c, e.d);
    model(ai, bi, ci, di, 1, e.midA, e.midB, e.midC, e.midD);
    e.iters   = it;
    e.latency = 4 * it * STEP;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [W-1:0] ai, bi, ci, di, input int it, input bit holdStart);
    bus.a_in  = ai;
    bus.b_in  = bi;
    bus.c_in  = ci;
    bus.d_in  = di;
    bus.iters = IW'(it);
    bus.abort = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    if (!holdStart) bus.start = 1'b0;
    pushExpected(ai, bi, ci, di, it);
  endtask

  // Called just after the accepting edge; n counts edges since acceptance.
  task automatic waitDone();
    exp_t e;
    int   n;
    int   busyCnt;
    logic seen;
    e       = sbQ.pop_front();
    n       = 0;
    seen    = bus.done;
    busyCnt = bus.busy ? 1 : 0;
    while (!seen && n < e.latency + 20) begin
      @(posedge clk); #1;
      n++;
      if (bus.busy) busyCnt++;
      if (n == STEP) checkOutput("stepAfterFirst", bus.step, 1);
      if (n == 4 * STEP && e.iters > 1) begin
        checkOutput("midIter", bus.iter, 1);
        checkOutput("midA", bus.a, e.midA);
        checkOutput("midB", bus.b, e.midB);
        checkOutput("midC", bus.c, e.midC);
        checkOutput("midD", bus.d, e.midD);
      end
      seen = bus.done;
    end
    checkOutput("doneSeen", seen, 1);
    checkOutput("latency", n, e.latency);
    checkOutput("busyCycles", busyCnt, e.latency);
    checkOutput("finalA", bus.a, e.a);
    checkOutput("finalB", bus.b, e.b);
    checkOutput("finalC", bus.c, e.c);
    checkOutput("finalD", bus.d, e.d);
    checkOutput("finalIter", bus.iter, e.iters);
    checkOutput("finalStep", bus.step, 0);
    checkOutput("busyAtDone", bus.busy, 0);
  endtask

  task automatic checkZeroState(input string tag);
    checkOutput({tag, "A"}, bus.a, 0);
    checkOutput({tag, "B"}, bus.b, 0);
    checkOutput({tag, "C"}, bus.c, 0);
    checkOutput({tag, "D"}, bus.d, 0);
    checkOutput({tag, "Busy"}, bus.busy, 0);
    checkOutput({tag, "Done"}, bus.done, 0);
    checkOutput({tag, "Step"}, bus.step, 0);
    checkOutput({tag, "Iter"}, bus.iter, 0);
  endtask

  initial begin
    logic seenFlag;
    exp_t dropped;

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.iters = '0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.c_in  = '0;
    bus.d_in  = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkZeroState("reset");
    rst = 1'b0;

    $display("[TB] nominal run");
    applyStimulus(32'd30, 32'd20, 32'd15, 32'd5, 4, 1'b0);
    checkOutput("busyAfterStart", bus.busy, 1);
    waitDone();
    @(posedge clk); #1;
    checkOutput("donePulseWidth", bus.done, 0);

    $display("[TB] reset mid-run");
    applyStimulus(32'd30, 32'd20, 32'd15, 32'd5, 4, 1'b0);
    repeat (36) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dropped = sbQ.pop_front();
    checkZeroState("midReset");
    applyStimulus(32'd30, 32'd20, 32'd15, 32'd5, 4, 1'b0);
    waitDone();

    $display("[TB] abort");
    applyStimulus(32'd30, 32'd20, 32'd15, 32'd5, 4, 1'b0);
    repeat (11) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    dropped = sbQ.pop_front();
    checkOutput("abortBusy", bus.busy, 0);
    checkOutput("abortA", bus.a, 35);
    checkOutput("abortD", bus.d, 32);
    checkOutput("abortB", bus.b, 20);
    checkOutput("abortC", bus.c, 15);
    checkOutput("abortStep", bus.step, 2);
    checkOutput("abortIter", bus.iter, 0);
    seenFlag = bus.done;
    repeat (30) begin
      @(posedge clk); #1;
      seenFlag = seenFlag | bus.done | bus.busy;
    end
    checkOutput("abortQuiet", seenFlag, 0);
    checkOutput("abortHoldA", bus.a, 35);

    $display("[TB] zero iterations");
    applyStimulus(32'd7, 32'd8, 32'd9, 32'd10, 0, 1'b0);
    checkOutput("zeroBusy", bus.busy, 0);
    waitDone();
    @(posedge clk); #1;
    checkOutput("zeroDoneWidth", bus.done, 0);
    checkOutput("zeroHoldA", bus.a, 7);

    $display("[TB] wrap-around");
    applyStimulus(32'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 1, 1'b0);
    waitDone();

    $display("[TB] start and abort together in idle");
    bus.a_in  = 32'd99;
    bus.b_in  = 32'd99;
    bus.c_in  = 32'd99;
    bus.d_in  = 32'd99;
    bus.iters = 8'd3;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checkOutput("startAbortBusy", bus.busy, 0);
    checkOutput("startAbortDone", bus.done, 0);
    checkOutput("startAbortA", bus.a, 32'h8000_0000);
    checkOutput("startAbortC", bus.c, 2);
    @(posedge clk); #1;
    checkOutput("startAbortStillIdle", bus.busy, 0);

    $display("[TB] start held through run and back-to-back");
    applyStimulus(32'd30, 32'd20, 32'd15, 32'd5, 1, 1'b1);
    bus.a_in  = 32'd1;
    bus.b_in  = 32'd2;
    bus.c_in  = 32'd3;
    bus.d_in  = 32'd4;
    bus.iters = 8'd2;
    waitDone();
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput("backToBackBusy", bus.busy, 1);
    pushExpected(32'd1, 32'd2, 32'd3, 32'd4, 2);
    waitDone();

    $display("[TB] random runs");
    for (int r = 0; r < 3; r++) begin
      applyStimulus($urandom, $urandom, $urandom, $urandom, $urandom_range(1, 3), 1'b0);
      waitDone();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
